mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and shared memory port seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  imem_read_v_i;
    logic [ADDR_W-1:0]     imem_addr_i;
    logic                  imem_resp_v_o;
    logic [DATA_W-1:0]     imem_data_o;

    logic                  dmem_read_v_i;
    logic                  dmem_write_v_i;
    logic [ADDR_W-1:0]     dmem_addr_i;
    logic [DATA_W-1:0]     dmem_wdata_i;
    logic [DATA_W/8-1:0]   dmem_wmask_i;
    logic                  dmem_resp_v_o;
    logic [DATA_W-1:0]     dmem_rdata_o;

    logic                  mem_v_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_wmask_o;
    logic                  mem_ready_i;
    logic                  mem_resp_v_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    modport slave (
        input  imem_read_v_i, imem_addr_i,
        output imem_resp_v_o, imem_data_o,
        input  dmem_read_v_i, dmem_write_v_i, dmem_addr_i, dmem_wdata_i, dmem_wmask_i,
        output dmem_resp_v_o, dmem_rdata_o,
        output mem_v_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_ready_i, mem_resp_v_i, mem_rdata_i
    );

    modport master (
        output imem_read_v_i, imem_addr_i,
        input  imem_resp_v_o, imem_data_o,
        output dmem_read_v_i, dmem_write_v_i, dmem_addr_i, dmem_wdata_i, dmem_wmask_i,
        input  dmem_resp_v_o, dmem_rdata_o,
        input  mem_v_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_ready_i, mem_resp_v_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single memory with one transaction in flight.
// Define MEM_ARBITER_RR_EN for round-robin on contention; otherwise the data port always wins.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    mem_arbiter_if.slave    bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic                owner;
    logic                imem_done;
    logic                dmem_done;
    logic                mem_v_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]   mem_wmask_q;
    logic [DATA_W-1:0]   imem_data_q;
    logic [DATA_W-1:0]   dmem_rdata_q;

    logic                imem_req;
    logic                dmem_req;
    logic                imem_pend;
    logic                dmem_pend;
    logic                advance;
    logic                grant;
    logic                grant_dmem;
    logic                land;

    assign imem_req  = bus.imem_read_v_i;
    assign dmem_req  = bus.dmem_read_v_i || bus.dmem_write_v_i;
    assign imem_pend = imem_req && !imem_done;
    assign dmem_pend = dmem_req && !dmem_done;
    assign advance   = (!imem_req || imem_done) && (!dmem_req || dmem_done);
    assign grant     = (state == IDLE) && (imem_pend || dmem_pend) && !reset_i;
    assign land      = (state == WAIT) && bus.mem_resp_v_i && !reset_i;

`ifdef MEM_ARBITER_RR_EN
    // Remembers the winner of the last contested grant, so back-to-back contested rounds alternate.
    logic rr_dmem_next;
    assign grant_dmem = dmem_pend && (!imem_pend || rr_dmem_next);
`else
    assign grant_dmem = dmem_pend;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            owner     <= 1'b0;
            imem_done <= 1'b0;
            dmem_done <= 1'b0;
            mem_v_q   <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            rr_dmem_next <= 1'b0;
`endif
        end else begin
            if (advance || !imem_req) imem_done <= 1'b0;
            if (advance || !dmem_req) dmem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (imem_pend || dmem_pend) begin
                        owner    <= grant_dmem;
                        mem_v_q  <= 1'b1;
                        mem_we_q <= grant_dmem && bus.dmem_write_v_i;
                        state    <= ISSUE;
`ifdef MEM_ARBITER_RR_EN
                        if (imem_pend && dmem_pend) rr_dmem_next <= !grant_dmem;
`endif
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready_i) begin
                        mem_v_q <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // A completion set here wins over any clear requested above in the same cycle.
                    if (bus.mem_resp_v_i) begin
                        if (owner) dmem_done <= 1'b1;
                        else       imem_done <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields and holding registers are data only and carry no reset.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            mem_addr_q  <= grant_dmem ? bus.dmem_addr_i : bus.imem_addr_i;
            mem_wdata_q <= bus.dmem_wdata_i;
            mem_wmask_q <= grant_dmem ? bus.dmem_wmask_i : '0;
        end
        if (land) begin
            if (!owner)         imem_data_q  <= bus.mem_rdata_i;
            else if (!mem_we_q) dmem_rdata_q <= bus.mem_rdata_i;
        end
    end

    assign bus.mem_v_o       = mem_v_q;
    assign bus.mem_we_o      = mem_we_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_wdata_o   = mem_wdata_q;
    assign bus.mem_wmask_o   = mem_wmask_q;
    assign bus.imem_resp_v_o = imem_done;
    assign bus.imem_data_o   = imem_data_q;
    assign bus.dmem_resp_v_o = dmem_done;
    assign bus.dmem_rdata_o  = dmem_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a pipeline driver plus a memory model with random stalls
// and latencies, checked against per-round expectations of grant order, fields and returned data.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    logic clk_i = 1'b0;
    logic reset_i;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int check_count = 0;
    int pass_count  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Memory model state and knobs
    bit                mem_pend = 0;
    int                mem_delay = 0;
    logic [DATA_W-1:0] mem_resp_data;
    int                ready_pct = 100;
    int                ready_hold = 0;
    int                delay_max = 0;
    bit                spurious_en = 0;
    bit                fixed_data_en = 0;
    logic [DATA_W-1:0] fixed_data;

    // Log of accepted memory requests and the data returned for each
    logic [ADDR_W-1:0] acc_addr[$];
    bit                acc_we[$];
    logic [DATA_W-1:0] acc_wdata[$];
    logic [MASK_W-1:0] acc_wmask[$];
    logic [DATA_W-1:0] resp_data_q[$];

    int stall_err = 0;
    int v_cycles  = 0;

    // Reference state: what each holding register must show, and the round-robin memory
    bit                exp_imem_valid = 0;
    logic [DATA_W-1:0] exp_imem_data;
    bit                exp_dmem_valid = 0;
    logic [DATA_W-1:0] exp_dmem_data;
    bit                last_contest_dmem = 1;

    task automatic clear_log();
        acc_addr.delete();
        acc_we.delete();
        acc_wdata.delete();
        acc_wmask.delete();
        resp_data_q.delete();
        stall_err = 0;
        v_cycles  = 0;
    endtask

    // One clock: memory-side inputs change at the falling edge, outputs are sampled 1ns after the rise.
    task automatic step();
        bit                stalled;
        logic [ADDR_W-1:0] s_addr;
        bit                s_we;
        logic [DATA_W-1:0] s_wdata;
        logic [MASK_W-1:0] s_wmask;
        @(negedge clk_i);
        bus.mem_resp_v_i = 1'b0;
        bus.mem_rdata_i  = $urandom;
        if (mem_pend) begin
            if (mem_delay == 0) begin
                bus.mem_resp_v_i = 1'b1;
                bus.mem_rdata_i  = mem_resp_data;
                mem_pend = 0;
            end else begin
                mem_delay--;
            end
        end else if (spurious_en && $urandom_range(9) == 0) begin
            bus.mem_resp_v_i = 1'b1;
        end
        if (bus.mem_v_o === 1'b1 && ready_hold > 0) begin
            bus.mem_ready_i = 1'b0;
            ready_hold--;
        end else begin
            bus.mem_ready_i = ($urandom_range(99) < ready_pct);
        end
        stalled = (bus.mem_v_o === 1'b1) && !bus.mem_ready_i;
        s_addr  = bus.mem_addr_o;
        s_we    = bus.mem_we_o;
        s_wdata = bus.mem_wdata_o;
        s_wmask = bus.mem_wmask_o;
        if (bus.mem_v_o === 1'b1 && bus.mem_ready_i) begin
            acc_addr.push_back(bus.mem_addr_o);
            acc_we.push_back(bus.mem_we_o);
            acc_wdata.push_back(bus.mem_wdata_o);
            acc_wmask.push_back(bus.mem_wmask_o);
            mem_pend      = 1;
            mem_delay     = $urandom_range(delay_max);
            mem_resp_data = fixed_data_en ? fixed_data : DATA_W'($urandom);
            resp_data_q.push_back(mem_resp_data);
        end
        @(posedge clk_i);
        #1;
        if (bus.mem_v_o === 1'b1) v_cycles++;
        if (stalled && (bus.mem_v_o !== 1'b1 || bus.mem_addr_o !== s_addr || bus.mem_we_o !== s_we ||
                        bus.mem_wdata_o !== s_wdata || bus.mem_wmask_o !== s_wmask))
            stall_err++;
    endtask

    task automatic drop_requests();
        bus.imem_read_v_i  = 1'b0;
        bus.dmem_read_v_i  = 1'b0;
        bus.dmem_write_v_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        drop_requests();
        step();
        step();
        reset_i = 1'b0;
        last_contest_dmem = 1;
    endtask

    // One pipeline round: raise requests (dmem possibly dlag cycles late), hold until every
    // requested port reports done, then drop and confirm both responses clear.
    task automatic applyStimulus(input string tag, input bit ireq, input int dkind,
                                 input logic [ADDR_W-1:0] iaddr, input logic [ADDR_W-1:0] daddr,
                                 input logic [DATA_W-1:0] wdata, input logic [MASK_W-1:0] wmask,
                                 input int dlag);
        int order[2];
        int exp_n;
        bit first_dmem;
        bit seen_i, seen_d, finished;
        int hold_err;
        int cycles;

        clear_log();
        if (ireq && dkind != 0) begin
            exp_n = 2;
            if (dlag > 0) begin
                first_dmem = 0;
            end else begin
`ifdef MEM_ARBITER_RR_EN
                first_dmem = !last_contest_dmem;
                last_contest_dmem = first_dmem;
`else
                first_dmem = 1;
`endif
            end
            order[0] = first_dmem ? 1 : 0;
            order[1] = first_dmem ? 0 : 1;
        end else begin
            exp_n    = 1;
            order[0] = ireq ? 0 : 1;
            order[1] = 0;
        end

        bus.imem_read_v_i = ireq;
        bus.imem_addr_i   = iaddr;
        bus.dmem_addr_i   = daddr;
        bus.dmem_wdata_i  = wdata;
        bus.dmem_wmask_i  = wmask;
        seen_i = 0;
        seen_d = 0;
        finished = 0;
        hold_err = 0;
        cycles = 0;
        while (!finished && cycles < 200) begin
            if (cycles == dlag) begin
                bus.dmem_read_v_i  = (dkind == 1);
                bus.dmem_write_v_i = (dkind == 2);
            end
            step();
            cycles++;
            if ((seen_i || !ireq) && bus.imem_resp_v_o !== seen_i) hold_err++;
            if ((seen_d || dkind == 0) && bus.dmem_resp_v_o !== seen_d) hold_err++;
            if (bus.imem_resp_v_o === 1'b1 && ireq) seen_i = 1;
            if (bus.dmem_resp_v_o === 1'b1 && dkind != 0 && cycles > dlag) seen_d = 1;
            finished = (!ireq || seen_i) && (dkind == 0 || seen_d);
        end
        checkOutput({tag, "_done"}, finished, 1'b1);
        checkOutput({tag, "_ntxn"}, acc_addr.size(), exp_n);
        for (int k = 0; k < exp_n && k < acc_addr.size(); k++) begin
            if (order[k] == 0) begin
                checkOutput({tag, "_iaddr"}, acc_addr[k], iaddr);
                checkOutput({tag, "_iwe"}, acc_we[k], 1'b0);
                exp_imem_valid = 1;
                exp_imem_data  = resp_data_q[k];
            end else begin
                checkOutput({tag, "_daddr"}, acc_addr[k], daddr);
                checkOutput({tag, "_dwe"}, acc_we[k], (dkind == 2));
                if (dkind == 2) begin
                    checkOutput({tag, "_wdata"}, acc_wdata[k], wdata);
                    checkOutput({tag, "_wmask"}, acc_wmask[k], wmask);
                end else begin
                    exp_dmem_valid = 1;
                    exp_dmem_data  = resp_data_q[k];
                end
            end
        end
        if (exp_imem_valid) checkOutput({tag, "_idata"}, bus.imem_data_o, exp_imem_data);
        if (exp_dmem_valid) checkOutput({tag, "_drdata"}, bus.dmem_rdata_o, exp_dmem_data);
        checkOutput({tag, "_resp_hold"}, hold_err, 0);
        checkOutput({tag, "_stable"}, stall_err, 0);
        drop_requests();
        step();
        checkOutput({tag, "_resp_clear"}, {bus.imem_resp_v_o, bus.dmem_resp_v_o}, 2'b00);
    endtask

    initial begin
        bit ireq;
        int dkind;
        int dlag;

        bus.mem_ready_i    = 1'b0;
        bus.mem_resp_v_i   = 1'b0;
        bus.mem_rdata_i    = '0;
        bus.imem_addr_i    = '0;
        bus.dmem_addr_i    = '0;
        bus.dmem_wdata_i   = '0;
        bus.dmem_wmask_i   = '0;
        do_reset();
        checkOutput("reset_outputs",
                    {bus.mem_v_o, bus.mem_we_o, bus.imem_resp_v_o, bus.dmem_resp_v_o}, 4'b0000);

        // Single instruction fetch with a ready memory answering the cycle after accept
        clear_log();
        ready_pct = 100;
        delay_max = 0;
        fixed_data_en = 1;
        fixed_data = 32'hDEADBEEF;
        bus.imem_read_v_i = 1'b1;
        bus.imem_addr_i   = 32'h100;
        step();
        checkOutput("fetch_c1_v", {bus.mem_v_o, bus.mem_we_o, bus.imem_resp_v_o}, 3'b100);
        checkOutput("fetch_c1_addr", bus.mem_addr_o, 32'h100);
        step();
        checkOutput("fetch_c2", {bus.mem_v_o, bus.imem_resp_v_o}, 2'b00);
        step();
        checkOutput("fetch_c3_resp", bus.imem_resp_v_o, 1'b1);
        checkOutput("fetch_c3_data", bus.imem_data_o, 32'hDEADBEEF);
        exp_imem_valid = 1;
        exp_imem_data  = 32'hDEADBEEF;
        drop_requests();
        step();
        checkOutput("fetch_clear", bus.imem_resp_v_o, 1'b0);
        checkOutput("fetch_ntxn", acc_addr.size(), 1);
        fixed_data_en = 0;

        // Simultaneous fetch and load, then a repeat to see arbitration across rounds
        applyStimulus("pair1", 1'b1, 1, 32'h100, 32'h200, 32'h0, 4'h0, 0);
        applyStimulus("pair2", 1'b1, 1, 32'h100, 32'h200, 32'h0, 4'h0, 0);

        // Store held off by a stalled memory for four cycles
        ready_hold = 4;
        applyStimulus("store", 1'b0, 2, 32'h0, 32'h40, 32'h12345678, 4'hF, 0);
        checkOutput("store_v_cycles", v_cycles, 5);

        // Fetch served early while a slow load keeps the fetch request high
        ready_pct = 50;
        delay_max = 3;
        applyStimulus("hold_fetch", 1'b1, 1, 32'h100, 32'h300, 32'h0, 4'h0, 1);

        // Reset while waiting for a response; the late response must be ignored
        clear_log();
        ready_pct = 100;
        delay_max = 0;
        bus.imem_read_v_i = 1'b1;
        bus.imem_addr_i   = 32'h500;
        step();
        step();
        mem_delay = 3;
        drop_requests();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        last_contest_dmem = 1;
        repeat (5) step();
        checkOutput("rst_wait_resp", {bus.mem_v_o, bus.imem_resp_v_o, bus.dmem_resp_v_o}, 3'b000);
        checkOutput("rst_wait_data", bus.imem_data_o, exp_imem_data);
        checkOutput("rst_wait_ntxn", acc_addr.size(), 1);

        // Randomized rounds with stalls, variable latency and stray response pulses
        spurious_en = 1;
        for (int r = 0; r < 40; r++) begin
            ireq  = 1'($urandom_range(1));
            dkind = $urandom_range(2);
            if (!ireq && dkind == 0) ireq = 1;
            dlag = (ireq && dkind != 0 && $urandom_range(3) == 0) ? $urandom_range(2, 1) : 0;
            ready_pct = $urandom_range(100, 30);
            delay_max = $urandom_range(3);
            applyStimulus($sformatf("rnd%0d", r), ireq, dkind, ADDR_W'($urandom), ADDR_W'($urandom),
                          DATA_W'($urandom), MASK_W'($urandom), dlag);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
